// File: rtl/risc_pkg.sv
// Shared decode-side constants and the LM/SM sequencer state encoding.
package risc_pkg;
  localparam logic [3:0]  LM_OP     = 4'b0110;
  localparam logic [3:0]  SM_OP     = 4'b0111;
  localparam logic [15:0] BUBBLE_IW = 16'hfffe;

  typedef enum logic {IDLE, SEQ} seq_state_e;
endpackage

// File: rtl/lmsm_prienc.sv
// Lowest-set-bit encoder for an 8-bit register list, with any/single flags.
module lmsm_prienc (
  input  logic [7:0] mask_i,
  output logic [2:0] idx_o,
  output logic       any_o,
  output logic       single_o
);
  always_comb begin
    idx_o = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (mask_i[i]) idx_o = i[2:0];
  end

  assign any_o    = |mask_i;
  assign single_o = any_o && ((mask_i & (mask_i - 8'd1)) == 8'd0);
endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM into one micro-op per list bit, holding IF/ID while expanding;
// everything else passes straight through combinationally.
module lmsm_sequencer #(
  parameter logic [3:0]  LM_OP     = risc_pkg::LM_OP,
  parameter logic [3:0]  SM_OP     = risc_pkg::SM_OP,
  parameter logic [15:0] BUBBLE_IW = risc_pkg::BUBBLE_IW
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] in_IW,
  input  logic [15:0] in_pc,
  input  logic        in_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic        stall_IF,
  output logic        uop_valid,
  output logic [15:0] uop_IW,
  output logic [15:0] uop_pc,
  output logic [2:0]  uop_reg,
  output logic [2:0]  uop_offset,
  output logic        uop_first,
  output logic        uop_last
);
  risc_pkg::seq_state_e state_q;
  logic [7:0]  mask_q;
  logic [2:0]  cnt_q;
  logic [15:0] iw_q, pc_q;

  logic [2:0] in_idx, m_idx;
  logic       in_any, in_single, m_any, m_single;
  logic       lmsm_in;
  logic       unused_bits;

  assign unused_bits = ^{in_IW[11:8], m_any};
  assign lmsm_in = in_valid && ((in_IW[15:12] == LM_OP) || (in_IW[15:12] == SM_OP));

  lmsm_prienc u_enc_in (
    .mask_i(in_IW[7:0]), .idx_o(in_idx), .any_o(in_any), .single_o(in_single)
  );
  lmsm_prienc u_enc_mask (
    .mask_i(mask_q), .idx_o(m_idx), .any_o(m_any), .single_o(m_single)
  );

  always_ff @(negedge clk) begin
    if (!resetn) begin
      state_q <= risc_pkg::IDLE;
      mask_q  <= 8'd0;
      cnt_q   <= 3'd0;
      iw_q    <= BUBBLE_IW;
      pc_q    <= 16'd0;
    end else if (flush) begin
      state_q <= risc_pkg::IDLE;
      mask_q  <= 8'd0;
      cnt_q   <= 3'd0;
    end else if (!stall_in) begin
      case (state_q)
        risc_pkg::IDLE:
          if (lmsm_in && in_any && !in_single) begin
            iw_q    <= in_IW;
            pc_q    <= in_pc;
            mask_q  <= in_IW[7:0] & ~(8'd1 << in_idx);
            cnt_q   <= 3'd1;
            state_q <= risc_pkg::SEQ;
          end
        risc_pkg::SEQ:
          if (m_single) begin
            mask_q  <= 8'd0;
            cnt_q   <= 3'd0;
            state_q <= risc_pkg::IDLE;
          end else begin
            mask_q <= mask_q & ~(8'd1 << m_idx);
            cnt_q  <= cnt_q + 3'd1;
          end
        default: state_q <= risc_pkg::IDLE;
      endcase
    end
  end

  // Fetch is released on the final micro-op so IF/ID advances exactly as it is consumed.
  always_comb begin
    stall_IF   = 1'b0;
    uop_valid  = 1'b0;
    uop_IW     = BUBBLE_IW;
    uop_pc     = 16'd0;
    uop_reg    = 3'd0;
    uop_offset = 3'd0;
    uop_first  = 1'b0;
    uop_last   = 1'b0;
    if (!resetn) begin
      stall_IF = 1'b0;
    end else if (flush) begin
      stall_IF = stall_in;
    end else if (state_q == risc_pkg::SEQ) begin
      uop_valid  = 1'b1;
      uop_IW     = iw_q;
      uop_pc     = pc_q;
      uop_reg    = m_idx;
      uop_offset = cnt_q;
      uop_last   = m_single;
      stall_IF   = stall_in || !m_single;
    end else if (!lmsm_in) begin
      uop_valid = in_valid;
      uop_IW    = in_IW;
      uop_pc    = in_pc;
      stall_IF  = stall_in;
    end else if (in_any) begin
      uop_valid = 1'b1;
      uop_IW    = in_IW;
      uop_pc    = in_pc;
      uop_reg   = in_idx;
      uop_first = 1'b1;
      uop_last  = in_single;
      stall_IF  = stall_in || !in_single;
    end else begin
      stall_IF = stall_in;
    end
  end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Random + directed bench for lmsm_sequencer against a list-position model.
module tb_lmsm_sequencer;
  logic        clk = 1'b0;
  logic        resetn, in_valid, stall_in, flush;
  logic [15:0] in_IW, in_pc;
  logic        stall_IF, uop_valid, uop_first, uop_last;
  logic [15:0] uop_IW, uop_pc;
  logic [2:0]  uop_reg, uop_offset;

  int total = 0, bad = 0;
  int pos = 0;
  bit adv;
  logic [15:0] nxt_iw, nxt_pc;
  logic        nxt_v;

  localparam logic [15:0] ADD_W = 16'h0050;

  lmsm_sequencer dut (
    .clk(clk), .resetn(resetn), .in_IW(in_IW), .in_pc(in_pc), .in_valid(in_valid),
    .stall_in(stall_in), .flush(flush), .stall_IF(stall_IF), .uop_valid(uop_valid),
    .uop_IW(uop_IW), .uop_pc(uop_pc), .uop_reg(uop_reg), .uop_offset(uop_offset),
    .uop_first(uop_first), .uop_last(uop_last)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_lmsm();
    return in_valid && (in_IW[15:12] == 4'b0110 || in_IW[15:12] == 4'b0111);
  endfunction

  // Register index of the p-th set bit of the list, counting from bit 0.
  function automatic logic [2:0] kth(logic [7:0] l, int p);
    int seen = 0;
    for (int i = 0; i < 8; i++)
      if (l[i]) begin
        if (seen == p) return i[2:0];
        seen++;
      end
    return 3'd0;
  endfunction

  task automatic compare();
    int n;
    n = $countones(in_IW[7:0]);
    if (!resetn) begin
      chk("rst_valid", uop_valid, 0); chk("rst_iw", uop_IW, 16'hfffe);
      chk("rst_pc", uop_pc, 0);       chk("rst_reg", uop_reg, 0);
      chk("rst_off", uop_offset, 0);  chk("rst_first", uop_first, 0);
      chk("rst_last", uop_last, 0);   chk("rst_stall", stall_IF, 0);
    end else if (flush || (is_lmsm() && n == 0)) begin
      chk("bub_valid", uop_valid, 0); chk("bub_iw", uop_IW, 16'hfffe);
      chk("bub_stall", stall_IF, stall_in);
    end else if (!is_lmsm()) begin
      chk("pt_valid", uop_valid, in_valid); chk("pt_iw", uop_IW, in_IW);
      chk("pt_pc", uop_pc, in_pc);          chk("pt_reg", uop_reg, 0);
      chk("pt_off", uop_offset, 0);         chk("pt_first", uop_first, 0);
      chk("pt_last", uop_last, 0);          chk("pt_stall", stall_IF, stall_in);
    end else begin
      chk("mo_valid", uop_valid, 1);          chk("mo_iw", uop_IW, in_IW);
      chk("mo_pc", uop_pc, in_pc);            chk("mo_reg", uop_reg, kth(in_IW[7:0], pos));
      chk("mo_off", uop_offset, pos[2:0]);    chk("mo_first", uop_first, pos == 0);
      chk("mo_last", uop_last, pos == n - 1);
      chk("mo_stall", stall_IF, stall_in || (pos < n - 1));
    end
  endtask

  task automatic model_step();
    int n;
    n = $countones(in_IW[7:0]);
    if (!resetn)                                   begin pos = 0; adv = 1; end
    else if (flush)                                begin pos = 0; adv = !stall_in; end
    else if (stall_in)                             adv = 0;
    else if (is_lmsm() && n >= 2 && pos < n - 1)   begin pos++; adv = 0; end
    else                                           begin pos = 0; adv = 1; end
  endtask

  // One clock: check mid-cycle, step the model on the active edge, then let IF/ID load.
  task automatic tick();
    @(posedge clk); compare();
    @(negedge clk); model_step();
    #1;
    if (adv) begin in_IW = nxt_iw; in_pc = nxt_pc; in_valid = nxt_v; end
  endtask

  task automatic set_nxt(logic [15:0] iw, logic [15:0] pc);
    nxt_iw = iw; nxt_pc = pc; nxt_v = 1'b1;
  endtask

  task automatic rand_nxt();
    logic [3:0] op;
    logic [7:0] l;
    int r = $urandom_range(0, 9);
    op = 4'($urandom_range(0, 15));
    l  = 8'($urandom);
    if (r <= 4) op = (r[0]) ? 4'b0110 : 4'b0111;
    else if (op == 4'b0110 || op == 4'b0111) op = 4'b0001;
    if (r == 4) begin
      case ($urandom_range(0, 2))
        0: l = 8'h00;
        1: l = 8'd1 << $urandom_range(0, 7);
        default: l = 8'hff;
      endcase
    end
    nxt_iw = {op, 4'($urandom), l};
    nxt_pc = 16'($urandom);
    nxt_v  = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    int sc, hold2, cons;
    logic [7:0] regs [4];
    regs = '{8'd0, 8'd2, 8'd5, 8'd7};
    resetn = 0; stall_in = 0; flush = 0;
    in_IW = 16'h60ff; in_pc = 16'h1234; in_valid = 1;
    set_nxt(ADD_W, 16'h0010);
    #1;
    chk("init_valid", uop_valid, 0); chk("init_iw", uop_IW, 16'hfffe);
    chk("init_stall", stall_IF, 0);
    tick(); tick();
    resetn = 1;
    tick();

    // LM 1010_0101 at 0x0040
    set_nxt(16'h60a5, 16'h0040); tick();
    set_nxt(ADD_W, 16'h0042);
    sc = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lm_reg", uop_reg, regs[k]);   chk("lm_off", uop_offset, k);
      chk("lm_first", uop_first, k == 0); chk("lm_last", uop_last, k == 3);
      chk("lm_pc", uop_pc, 16'h0040);
      sc += stall_IF;
      tick();
    end
    chk("lm_stallcnt", sc, 3);
    #1;
    chk("add_valid", uop_valid, 1); chk("add_iw", uop_IW, ADD_W);
    chk("add_stall", stall_IF, 0);  chk("add_reg", uop_reg, 0);

    // SM empty list, then LM with only R7
    set_nxt(16'h7000, 16'h0044); tick(); #1;
    chk("sm0_valid", uop_valid, 0); chk("sm0_iw", uop_IW, 16'hfffe); chk("sm0_stall", stall_IF, 0);
    set_nxt(16'h6080, 16'h0046); tick(); #1;
    chk("lm80_reg", uop_reg, 7); chk("lm80_first", uop_first, 1);
    chk("lm80_last", uop_last, 1); chk("lm80_stall", stall_IF, 0);

    // LM 0xFF with two stall_in cycles on the third micro-op
    set_nxt(16'h60ff, 16'h0048); tick();
    set_nxt(ADD_W, 16'h004a);
    sc = 0; hold2 = 0; cons = 0;
    for (int c = 0; c < 10; c++) begin
      stall_in = (c == 2 || c == 3);
      #1;
      sc += stall_IF;
      if (uop_reg == 3'd2) hold2++;
      if (!stall_in) begin
        chk("ff_reg", uop_reg, cons); chk("ff_off", uop_offset, cons);
        cons++;
      end
      tick();
    end
    stall_in = 0;
    chk("ff_stallcnt", sc, 9); chk("ff_hold2", hold2, 3); chk("ff_cons", cons, 8);

    // LM 0x0F flushed on its second micro-op
    set_nxt(16'h600f, 16'h0050); tick(); tick();
    flush = 1; #1;
    chk("fl_valid", uop_valid, 0); chk("fl_stall", stall_IF, 0);
    set_nxt(ADD_W, 16'h0052); tick();
    flush = 0; #1;
    chk("fl_add_iw", uop_IW, ADD_W); chk("fl_add_valid", uop_valid, 1);

    // LM 0x3F with reset during its third micro-op
    set_nxt(16'h603f, 16'h0054); tick(); tick(); tick();
    resetn = 0; #1;
    chk("rs_valid", uop_valid, 0); chk("rs_iw", uop_IW, 16'hfffe);
    chk("rs_pc", uop_pc, 0);       chk("rs_stall", stall_IF, 0);
    set_nxt(ADD_W, 16'h0056); tick();
    resetn = 1; #1;
    chk("rs_add_iw", uop_IW, ADD_W); chk("rs_add_pc", uop_pc, 16'h0056);
    set_nxt(16'h6003, 16'h0058); tick(); #1;
    chk("rs_lm_off", uop_offset, 0); chk("rs_lm_first", uop_first, 1);

    for (int c = 0; c < 3000; c++) begin
      rand_nxt();
      tick();
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      resetn   = ($urandom_range(0, 49) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
